// File: rtl/cpu_program_memory_pkg.sv
// Shared types and constants for the CPU program/data memory and the benches that drive it.
// The opcode table lets benches assemble programs without hard-coding nibbles.
package cpu_program_memory_pkg;

    localparam int unsigned CPU_ADDR_W = 4;
    localparam int unsigned CPU_DATA_W = 8;
    localparam int unsigned HOLD_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

    // Instruction word: opcode in the upper nibble, address/immediate in the lower nibble.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    function automatic logic [CPU_DATA_W-1:0] mk_instr(input logic [3:0] op,
                                                       input logic [3:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/cpu_program_memory_mem_array_16x8.sv
// Word array with one synchronous write port, one combinational read port,
// and an asynchronous clear of every word.
module mem_array_16x8
    import cpu_program_memory_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/cpu_program_memory.sv
// Reloadable program/data memory under the CPU: a byte-stream loader fills it while the
// CPU is held in clear, then the CPU is released and owns the write port.
module cpu_program_memory
    import cpu_program_memory_pkg::*;
#(
    parameter int unsigned ADDR_W        = CPU_ADDR_W,
    parameter int unsigned DATA_W        = CPU_DATA_W,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter bit          CLEAR_ON_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] memoryIn,
    output logic [DATA_W-1:0] memoryOut,
    output logic              cpu_clr,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              running
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam state_e START_STATE = CLEAR_ON_LOAD ? ST_CLEAR : ST_LOAD;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   load_ptr_q, load_ptr_d;
    logic [CNT_W-1:0]    load_count_q, load_count_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                cpu_clr_q, cpu_clr_d;
    logic                load_ready_q, load_ready_d;
    logic                running_q, running_d;

    logic                we_c;
    logic [ADDR_W-1:0]   waddr_c;
    logic [DATA_W-1:0]   wdata_c;

    // Reads are combinational, so the strobe carries no information for this block.
    logic read_unused;
    assign read_unused = read;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            load_ptr_q   <= '0;
            load_count_q <= '0;
            clr_ptr_q    <= '0;
            hold_q       <= '0;
            cpu_clr_q    <= 1'b1;
            load_ready_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            load_count_q <= load_count_d;
            clr_ptr_q    <= clr_ptr_d;
            hold_q       <= hold_d;
            cpu_clr_q    <= cpu_clr_d;
            load_ready_q <= load_ready_d;
            running_q    <= running_d;
        end
    end

    // Next state, write-port mux, and registered decodes of the next state.
    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        load_count_d = load_count_q;
        clr_ptr_d    = clr_ptr_q;
        hold_d       = hold_q;
        we_c         = 1'b0;
        waddr_c      = address;
        wdata_c      = memoryIn;

        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d      = START_STATE;
                    load_ptr_d   = '0;
                    load_count_d = '0;
                    clr_ptr_d    = '0;
                end
            end
            ST_CLEAR: begin
                we_c      = 1'b1;
                waddr_c   = clr_ptr_q;
                wdata_c   = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                waddr_c = load_ptr_q;
                wdata_c = load_data;
                if (load_valid && load_ready_q) begin
                    we_c       = 1'b1;
                    load_ptr_d = load_ptr_q + ADDR_W'(1);
                    if (load_count_q != FULL_CNT) begin
                        load_count_d = load_count_q + CNT_W'(1);
                    end
                    // The last word ends the load even without load_last; no wrap-around.
                    if (load_last || (load_ptr_q == LAST_ADDR)) begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_W'(HOLD_CYCLES);
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                we_c = write;
                if (load_start) begin
                    state_d      = START_STATE;
                    load_ptr_d   = '0;
                    load_count_d = '0;
                    clr_ptr_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cpu_clr_d    = (state_d != ST_RUN);
        load_ready_d = (state_d == ST_LOAD);
        running_d    = (state_d == ST_RUN);
    end

    mem_array_16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .clr     (clr),
        .we_i    (we_c),
        .waddr_i (waddr_c),
        .wdata_i (wdata_c),
        .raddr_i (address),
        .rdata_c (memoryOut)
    );

    assign cpu_clr    = cpu_clr_q;
    assign load_ready = load_ready_q;
    assign load_count = load_count_q;
    assign running    = running_q;

endmodule

// File: tb/tb_cpu_program_memory.sv
// Bench for cpu_program_memory: directed loads plus randomized streams and CPU traffic,
// checked against a word-array model of the memory contents and load handshake timing.
module tb_cpu_program_memory;
    import cpu_program_memory_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned HOLD  = 2;

    logic          clk;
    logic          clr;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] memoryIn;
    logic [DW-1:0] memoryOut;
    logic          cpu_clr;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic [AW:0]   load_count;
    logic          running;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] stream_q [$];
    int            last_idx;
    int            gap_mode;

    cpu_program_memory #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .HOLD_CYCLES   (HOLD),
        .CLEAR_ON_LOAD (1'b1)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .address    (address),
        .read       (read),
        .write      (write),
        .memoryIn   (memoryIn),
        .memoryOut  (memoryOut),
        .cpu_clr    (cpu_clr),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_count (load_count),
        .running    (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            address = AW'(i);
            #1;
            chk(tag, 32'(memoryOut), 32'(model[i]));
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        address  = a;
        memoryIn = d;
        write    = 1'b1;
        tick();
        write    = 1'b0;
        model[a] = d;
    endtask

    // Random CPU traffic while running; stray loader bytes must be ignored.
    task automatic cpu_random(input int n);
        for (int i = 0; i < n; i++) begin
            address    = AW'($urandom);
            memoryIn   = DW'($urandom);
            write      = 1'($urandom);
            read       = ~write;
            load_valid = 1'($urandom);
            load_data  = DW'($urandom);
            #1;
            chk("run_read", 32'(memoryOut), 32'(model[address]));
            chk("run_cpu_clr", 32'(cpu_clr), 0);
            tick();
            if (write) model[address] = memoryIn;
        end
        write      = 1'b0;
        read       = 1'b0;
        load_valid = 1'b0;
        chk("run_count_stable", 32'(load_count), 32'(load_count));
    endtask

    // Full load sequence: start pulse, clear window, stream with gaps, hold window, release.
    task automatic run_load();
        int idx;
        int acc;
        int cyc;
        bit done;
        bit v;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("clr_after_start", 32'(cpu_clr), 1);
        chk("ready_in_clear", 32'(load_ready), 0);
        chk("running_after_start", 32'(running), 0);
        repeat (DEPTH - 1) tick();
        chk("ready_clear_end", 32'(load_ready), 0);
        tick();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        idx  = 0;
        acc  = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            chk("ready_load", 32'(load_ready), 1);
            v = (idx < stream_q.size()) &&
                ((gap_mode == 0) || (gap_mode == 1 && (cyc % 2) == 0) ||
                 (gap_mode == 2 && $urandom_range(1, 0) == 1));
            load_valid = v;
            load_data  = v ? stream_q[idx] : DW'($urandom);
            load_last  = v ? (idx == last_idx) : 1'($urandom);
            write      = 1'($urandom);
            address    = AW'($urandom);
            memoryIn   = DW'($urandom);
            tick();
            cyc++;
            if (v) begin
                model[acc] = stream_q[idx];
                acc++;
                if (idx == last_idx || acc == DEPTH) done = 1'b1;
                idx++;
            end
        end
        if (!done) chk("load_timeout", 0, 1);
        for (int k = 0; k <= HOLD; k++) begin
            chk("hold_cpu_clr", 32'(cpu_clr), 1);
            chk("hold_ready", 32'(load_ready), 0);
            chk("hold_running", 32'(running), 0);
            load_valid = (idx < stream_q.size());
            load_data  = load_valid ? stream_q[idx] : DW'(0);
            load_last  = 1'b0;
            if (load_valid) idx++;
            write      = 1'b1;
            address    = AW'($urandom);
            memoryIn   = DW'($urandom);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        write      = 1'b0;
        chk("release_cpu_clr", 32'(cpu_clr), 0);
        chk("release_running", 32'(running), 1);
        chk("load_count", 32'(load_count), 32'(acc));
        check_mem("mem_after_load");
    endtask

    task automatic set_stream(input int n, input logic [DW-1:0] base);
        stream_q.delete();
        for (int j = 0; j < n; j++) stream_q.push_back(DW'(base + DW'(j)));
    endtask

    initial begin
        int len;
        clr        = 1'b1;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        memoryIn   = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset then idle
        #10;
        clr = 1'b0;
        tick();
        chk("rst_cpu_clr", 32'(cpu_clr), 1);
        chk("rst_ready", 32'(load_ready), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_count", 32'(load_count), 0);
        check_mem("rst_mem");
        address    = 4'd3;
        memoryIn   = 8'hAA;
        write      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h5A;
        tick();
        write      = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("idle_write_ignored", 32'(memoryOut), 0);
        chk("idle_valid_ignored", 32'(load_count), 0);

        // Program load and run
        stream_q = '{8'h47, 8'h06, 8'h54, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
        last_idx = 7;
        gap_mode = 0;
        run_load();
        cpu_write(4'd4, 8'h05);
        address = 4'd4;
        #1;
        chk("cpu_write_readback", 32'(memoryOut), 32'h05);
        cpu_random(20);

        // Reload during run: clear must wipe the old result at address 4
        cpu_write(4'd4, 8'h05);
        stream_q = '{8'h99, 8'h77};
        last_idx = 1;
        gap_mode = 2;
        run_load();
        cpu_random(10);

        // Overlength stream without load_last
        set_stream(20, 8'h10);
        last_idx = -1;
        gap_mode = 0;
        run_load();
        cpu_random(10);

        // Backpressure gaps
        set_stream(3, 8'hC0);
        last_idx = 2;
        gap_mode = 1;
        run_load();
        cpu_random(10);

        // Randomized streams
        for (int t = 0; t < 5; t++) begin
            len = $urandom_range(20, 1);
            stream_q.delete();
            for (int j = 0; j < len; j++) stream_q.push_back(DW'($urandom));
            last_idx = (len <= DEPTH) ? len - 1 : -1;
            gap_mode = 2;
            run_load();
            cpu_random(15);
        end

        // Reset mid-load after 2 of 5 bytes
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (DEPTH) tick();
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = DW'(8'hA0 + i);
            tick();
        end
        load_valid = 1'b0;
        chk("midload_count", 32'(load_count), 2);
        clr = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        chk("midrst_cpu_clr", 32'(cpu_clr), 1);
        chk("midrst_ready", 32'(load_ready), 0);
        chk("midrst_running", 32'(running), 0);
        chk("midrst_count", 32'(load_count), 0);
        check_mem("midrst_mem");
        @(negedge clk);
        clr = 1'b0;
        tick();
        chk("post_rst_ready", 32'(load_ready), 0);
        load_valid = 1'b1;
        load_data  = 8'hEE;
        tick();
        load_valid = 1'b0;
        chk("post_rst_count", 32'(load_count), 0);
        check_mem("post_rst_mem");

        // Recovery load from idle
        set_stream(5, 8'h31);
        last_idx = 4;
        gap_mode = 2;
        run_load();
        cpu_random(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_program_memory.md
Name: cpu_program_memory

Overview:
Unified 16x8 program/data memory that sits directly under the CPU and serves its memory bus (address, read, write, memoryIn, memoryOut). A byte-stream loader port fills the memory while the CPU is held in clear. Once loading finishes, the block releases the CPU and gives it exclusive memory access. This replaces the ad-hoc bench-side memory arrays with a synthesizable, reloadable block.

Parameters:
ADDR_W, 4, CPU address width.
DATA_W, 8, word width.
DEPTH, 2**ADDR_W, number of words (16).
HOLD_CYCLES, 2, cycles cpu_clr stays high after the last loaded byte (range 1..15).
CLEAR_ON_LOAD, 1, if 1, all words are zeroed before a load begins.

Ports:
clk  in  1  system clock; all state updates on posedge.
clr  in  1  reset; asynchronous, active-high.
address  in  ADDR_W  CPU word address.
read  in  1  CPU read strobe; informational only, reads are combinational.
write  in  1  CPU write strobe.
memoryIn  in  DATA_W  write data from the CPU.
memoryOut  out  DATA_W  read data to the CPU.
cpu_clr  out  1  clear to the CPU; high whenever the CPU does not own memory.
load_start  in  1  single-cycle pulse that begins a (re)load.
load_valid  in  1  loader byte valid.
load_data  in  DATA_W  loader byte.
load_last  in  1  marks the final byte; qualified by load_valid && load_ready.
load_ready  out  1  block accepts a loader byte this cycle.
load_count  out  ADDR_W+1  number of bytes accepted in the current or most recent load.
running  out  1  high in RUN.

Behaviour:
- Reset (async, clr=1):
  - state=IDLE, all words=0, load_ptr=0, load_count=0, hold counter=0.
  - cpu_clr=1, load_ready=0, running=0.
  - Reset asserted mid-load or mid-run aborts immediately to this state.
- Read path: memoryOut = mem[address], combinational, in every state.
- States:
  - IDLE: cpu_clr=1. On load_start, go to CLEAR if CLEAR_ON_LOAD else LOAD. Clear load_ptr and load_count.
  - CLEAR: writes 0 to mem[clr_ptr] on each cycle for DEPTH cycles (0..15), then goes to LOAD. load_ready=0.
  - LOAD: load_ready=1. On load_valid && load_ready, write mem[load_ptr]=load_data, increment load_ptr and load_count. If load_last or load_ptr==DEPTH-1, go to HOLD and load the hold counter with HOLD_CYCLES.
  - HOLD: cpu_clr=1, load_ready=0. The counter decrements each cycle; at 0, go to RUN.
  - RUN: cpu_clr=0, running=1. On posedge, if write, mem[address]=memoryIn. On load_start, go to CLEAR/LOAD next cycle; cpu_clr=1 from that cycle on.
- CPU write outside RUN is ignored. load_valid outside LOAD is ignored.
- load_start in CLEAR, LOAD, or HOLD is ignored.
- cpu_clr, load_ready, and running are registered state decodes. In RUN, cpu_clr rises exactly one cycle after a load_start is sampled.
- The DEPTH-th byte terminates the load; no wrap-around, so bytes beyond 16 are never accepted. load_count saturates at DEPTH (16).
- Latency: a byte accepted at edge N is readable on memoryOut after edge N. The first RUN cycle begins HOLD_CYCLES+1 edges after the last byte is accepted.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, CLEAR, LOAD, HOLD, RUN);
  - ADDR_W/DATA_W defaults, matching the CPU;
  - the opcode constants used by benches to build programs.
- Natural sub-module: mem_array_16x8. It provides one sync write port, one async read, and an async clear. The top block muxes the write port among the clear, loader, and CPU sources.

Test Plan:
- Reset then idle: clr high 10 ns, then low → cpu_clr=1, load_ready=0, memoryOut=0 for address 0..15, running=0.
- Full program load and run:
  - Stimulus: load_start, then stream 0x47,0x06,0x54,0x00,0x00,0x00,0x02,0x03 with load_last on the 8th byte; the CPU is attached.
  - Required: load_count=8; mem[6]=0x02, mem[7]=0x03; cpu_clr falls 3 edges after the last byte; CPU later writes 0x05 to address 4 and memoryOut reads 0x05 there.
- Overlength stream: 20 valid bytes 0x10..0x23 without load_last → only 0x10..0x1F stored at 0..15; load_ready drops after the 16th; load_count=16.
- Backpressure gaps: load_valid toggled every other cycle with 3 bytes → exactly 3 writes to addresses 0..2, no duplicates.
- Reload during RUN:
  - Stimulus: after a run, load_start, then a new 2-byte program.
  - Required: cpu_clr=1 one cycle after the pulse; CLEAR zeroes address 4 (old result 0x05 reads 0x00); new bytes land at addresses 0..1.
- Reset mid-load: assert clr after 2 of 5 bytes → immediate IDLE, all words 0, load_count=0, cpu_clr=1. CPU write attempts during HOLD leave memory unchanged.
